// File: rtl/ssd_pkg.sv
// Shared definitions for seven-segment display blocks.
//   IDX_W     : width of a digit index (up to 8 digits)
//   SEG_BLANK : cathode pattern with every segment and the point off
//   hex_seg() : 4-bit hex value -> active-low segments {a,b,c,d,e,f,g}
package ssd_pkg;

    localparam int IDX_W = 3;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   hex_i : 4-bit value
//   seg_o : active-low segments {a,b,c,d,e,f,g}
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_seg(hex_i);

endmodule

// File: rtl/ssd_scan_controller.sv
// N-digit time-multiplexed seven-segment scan controller.
//   Clk, Reset     : clock, asynchronous active-low reset
//   digits_in      : hex digits, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in          : per-digit decimal point (1 = lit)
//   digit_en       : per-digit enable (0 = always dark)
//   blink_en       : per-digit blink (dark while blink phase is 1)
//   blank_lz       : leading-zero blanking enable
//   load           : strobe; digits_in/dp_in are taken at the next frame wrap
//   An             : active-low anodes, one-cold at the scanned digit
//   Cathodes       : active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}
//   scan_idx       : digit currently being scanned
//   frame_done     : one-cycle pulse after the index wraps to 0
//
// Handshake: load is a fire-and-forget strobe with no ready; any number of
// strobes inside one frame collapse into a single capture at the wrap tick,
// using the digits_in/dp_in values present in that tick cycle.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_BITS   = 18,
    parameter int GUARD_CYCLES = 64,
    parameter int BLINK_BITS   = 25
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cathodes,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_done
);

    logic [DWELL_BITS-1:0]   dwell_q, dwell_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [BLINK_BITS-1:0]   blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              cath_q, cath_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap_tick;
    logic [4*NUM_DIGITS-1:0] dig_shift;
    logic [NUM_DIGITS-1:0]   dp_shift;
    logic [NUM_DIGITS-1:0]   en_shift;
    logic [NUM_DIGITS-1:0]   blink_shift;
    logic                    lz_blank;
    logic                    dark;
    logic                    in_guard;
    logic [6:0]              cur_seg;

    assign tick      = &dwell_q;
    assign wrap_tick = tick && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));

    // Shifting the scanned digit down to bit 0 gives its value in the low
    // bits and, as a whole word, "this digit and everything above it".
    assign dig_shift   = shadow_dig_q >> {scan_idx_q, 2'b00};
    assign dp_shift    = shadow_dp_q >> scan_idx_q;
    assign en_shift    = digit_en >> scan_idx_q;
    assign blink_shift = blink_en >> scan_idx_q;

    // Leading-zero blanking follows the captured point bits so it never
    // disagrees with the point actually being displayed.
    assign lz_blank = blank_lz && (scan_idx_q != '0) &&
                      (dig_shift == '0) && (dp_shift == '0);
    assign dark     = !en_shift[0] || (blink_shift[0] && blink_phase_q) || lz_blank;
    assign in_guard = dwell_q < DWELL_BITS'(GUARD_CYCLES);

    ssd_hex_decoder u_dec (
        .hex_i (dig_shift[3:0]),
        .seg_o (cur_seg)
    );

    always_comb begin
        dwell_d        = dwell_q + DWELL_BITS'(1);
        scan_idx_d     = scan_idx_q;
        blink_cnt_d    = blink_cnt_q + BLINK_BITS'(1);
        blink_phase_d  = blink_phase_q ^ (&blink_cnt_q);
        shadow_dig_d   = shadow_dig_q;
        shadow_dp_d    = shadow_dp_q;
        load_pending_d = load_pending_q || load;
        frame_done_d   = wrap_tick;
        an_d           = '1;
        cath_d         = SEG_BLANK;

        if (tick) begin
            scan_idx_d = wrap_tick ? '0 : scan_idx_q + IDX_W'(1);
        end

        // Capture only at the frame boundary so a frame is never torn.
        if (wrap_tick) begin
            if (load_pending_q || load) begin
                shadow_dig_d = digits_in;
                shadow_dp_d  = dp_in;
            end
            load_pending_d = 1'b0;
        end

        if (!in_guard && !dark) begin
            an_d   = ~(NUM_DIGITS'(1) << scan_idx_q);
            cath_d = {cur_seg, ~dp_shift[0]};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dwell_q        <= '0;
            scan_idx_q     <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            shadow_dig_q   <= '0;
            shadow_dp_q    <= '0;
            load_pending_q <= 1'b0;
            an_q           <= '1;
            cath_q         <= SEG_BLANK;
            frame_done_q   <= 1'b0;
        end else begin
            dwell_q        <= dwell_d;
            scan_idx_q     <= scan_idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            shadow_dig_q   <= shadow_dig_d;
            shadow_dp_q    <= shadow_dp_d;
            load_pending_q <= load_pending_d;
            an_q           <= an_d;
            cath_q         <= cath_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign An         = an_q;
    assign Cathodes   = cath_q;
    assign scan_idx   = scan_idx_q;
    assign frame_done = frame_done_q;

endmodule
